// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad-driven door lock controller. Steers the external four-digit
// entry shift register, checks the code on ENTER, times the unlock window and the alarm lockout.
module lock_ctrl #(
   parameter logic [15:0] SECRET         = 16'h4321,
   parameter int          OPEN_CYCLES    = 50000000,
   parameter int          LOCKOUT_CYCLES = 250000000,
   parameter int          MAX_FAILS      = 3
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic [15:0] code_i,
   output logic        sr_ce,
   output logic        sr_clr,
   output logic        unlock,
   output logic        alarm,
   output logic        err,
   output logic [2:0]  digit_cnt
);

   // state   | meaning
   // ENTRY   | collecting digits; CLEAR and ENTER honoured
   // CHECK   | single cycle compare of code_i against SECRET
   // OPEN    | unlock high while the timer runs down to zero
   // LOCKOUT | alarm high while the timer runs down; all keys dropped
   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      CHECK   = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   localparam int            TMAX       = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int            TW         = $clog2(TMAX + 1);
   localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [2:0]    FAIL_LIMIT = 3'(MAX_FAILS);

   state_t        state;
   state_t        state_nx;
   logic [TW-1:0] timer;
   logic [2:0]    fail_cnt;
   logic          key_digit;
   logic          key_enter;
   logic          key_clear;
   logic          match;
   logic          fail_hit;
   logic          timer_done;
   logic          unlock_nx;
   logic          alarm_nx;
   logic          err_nx;
   logic          sr_clr_nx;

   assign key_digit  = key_valid && (key_code <= 4'd9);
   assign key_enter  = key_valid && (key_code == 4'hA);
   assign key_clear  = key_valid && (key_code == 4'hB);
   assign match      = (digit_cnt == 3'd4) && (code_i == SECRET);
   assign fail_hit   = (fail_cnt + 3'd1) >= FAIL_LIMIT;
   assign timer_done = (timer == '0);

   // State and registered outputs share one register process.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= ENTRY;
         unlock <= 1'b0;
         alarm  <= 1'b0;
         err    <= 1'b0;
         sr_clr <= 1'b0;
      end else begin
         state  <= state_nx;
         unlock <= unlock_nx;
         alarm  <= alarm_nx;
         err    <= err_nx;
         sr_clr <= sr_clr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ENTRY: begin
            if (key_enter) state_nx = CHECK;
         end
         CHECK: begin
            if (match)         state_nx = OPEN;
            else if (fail_hit) state_nx = LOCKOUT;
            else               state_nx = ENTRY;
         end
         OPEN, LOCKOUT: begin
            if (timer_done) state_nx = ENTRY;
         end
         default: state_nx = ENTRY;
      endcase
   end

   // unlock/alarm follow the next state so they rise on the first OPEN/LOCKOUT cycle.
   always_comb begin
      sr_ce     = key_digit && (state == ENTRY) && (digit_cnt < 3'd4);
      unlock_nx = (state_nx == OPEN);
      alarm_nx  = (state_nx == LOCKOUT);
      err_nx    = (state == CHECK) && !match;
      sr_clr_nx = (state == CHECK) || ((state == ENTRY) && key_clear);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         digit_cnt <= '0;
         fail_cnt  <= '0;
         timer     <= '0;
      end else begin
         case (state)
            ENTRY: begin
               if (key_clear)  digit_cnt <= '0;
               else if (sr_ce) digit_cnt <= digit_cnt + 3'd1;
            end
            CHECK: begin
               digit_cnt <= '0;
               if (match) begin
                  fail_cnt <= '0;
                  timer    <= OPEN_LOAD;
               end else begin
                  fail_cnt <= fail_cnt + 3'd1;
                  if (fail_hit) timer <= LOCK_LOAD;
               end
            end
            OPEN: begin
               if (!timer_done) timer <= timer - TW'(1);
            end
            LOCKOUT: begin
               if (timer_done) fail_cnt <= '0;
               else            timer    <= timer - TW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lock_ctrl.sv
// Testbench for lock_ctrl: models the entry shift register, runs a key-sequence
// table, hand-written corner sequences and random keys against a cycle reference model.
`timescale 1ns/1ps
module tb_lock_ctrl;

   localparam int          OPEN_N  = 8;
   localparam int          LOCK_N  = 16;
   localparam int          FAILS_N = 3;
   localparam logic [15:0] SECRET  = 16'h4321;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic [15:0] code_i;
   logic        sr_ce;
   logic        sr_clr;
   logic        unlock;
   logic        alarm;
   logic        err;
   logic [2:0]  digit_cnt;

   int errors = 0;
   int checks = 0;

   lock_ctrl #(
      .SECRET(SECRET), .OPEN_CYCLES(OPEN_N), .LOCKOUT_CYCLES(LOCK_N), .MAX_FAILS(FAILS_N)
   ) dut (
      .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code), .code_i(code_i),
      .sr_ce(sr_ce), .sr_clr(sr_clr), .unlock(unlock), .alarm(alarm), .err(err),
      .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   // Entry shift register: newest digit enters at [15:12].
   logic [15:0] entry_reg;
   assign code_i = entry_reg;
   always @(posedge clk or negedge clr) begin
      if (!clr)        entry_reg <= 16'h0;
      else if (sr_ce)  entry_reg <= {key_code, (sr_clr ? 12'h000 : entry_reg[15:4])};
      else if (sr_clr) entry_reg <= 16'h0;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: digits typed, pending check, remaining open/alarm cycles.
   int m_digits[$];
   bit m_check = 0;
   int m_open = 0;
   int m_alarm = 0;
   int m_fails = 0;
   bit m_err = 0;
   bit m_clr = 0;

   function automatic bit m_idle();
      return !m_check && (m_open == 0) && (m_alarm == 0);
   endfunction

   function automatic int m_value();
      int v = 0;
      for (int i = 0; i < m_digits.size(); i++) v = v | (m_digits[i] << (4 * i));
      return v;
   endfunction

   task automatic model_step(input bit kv, input int kc);
      m_err = 0;
      m_clr = 0;
      if (m_check) begin
         m_check = 0;
         m_clr   = 1;
         if (m_digits.size() == 4 && m_value() == int'(SECRET)) begin
            m_open  = OPEN_N;
            m_fails = 0;
         end else begin
            m_err = 1;
            m_fails++;
            if (m_fails >= FAILS_N) begin
               m_alarm = LOCK_N;
               m_fails = 0;
            end
         end
         m_digits.delete();
      end else if (m_open > 0) begin
         m_open--;
      end else if (m_alarm > 0) begin
         m_alarm--;
      end else if (kv) begin
         if (kc <= 9) begin
            if (m_digits.size() < 4) m_digits.push_back(kc);
         end else if (kc == 10) begin
            m_check = 1;
         end else if (kc == 11) begin
            m_digits.delete();
            m_clr = 1;
         end
      end
   endtask

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_digits.delete();
         m_check = 0; m_open = 0; m_alarm = 0; m_fails = 0; m_err = 0; m_clr = 0;
      end else begin
         model_step(key_valid, int'(key_code));
      end
   end

   // Every cycle, compare DUT outputs against the model.
   always @(negedge clk) begin
      #2;
      check("unlock", unlock, m_open > 0);
      check("alarm", alarm, m_alarm > 0);
      check("err", err, m_err);
      check("sr_clr", sr_clr, m_clr);
      check("digit_cnt", digit_cnt, m_digits.size());
      check("sr_ce", sr_ce, key_valid && (key_code <= 4'd9) && m_idle() && (m_digits.size() < 4));
      check("unlock_alarm_excl", unlock & alarm, 1'b0);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic enter_keys(input logic [31:0] keys, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         press(keys[4*i +: 4]);
         idle(gap);
      end
   endtask

   task automatic wait_high(input string name, input bit sel_alarm, input int budget);
      int n = 0;
      while (!(sel_alarm ? alarm : unlock) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, n < budget, 1'b1);
   endtask

   task automatic reset_pulse();
      clr = 1'b0;
      idle(2);
      clr = 1'b1;
   endtask

   typedef struct {
      logic [31:0] keys;
      int          nkeys;
      int          exp_cnt;
      bit          exp_open;
   } vec_t;

   vec_t tbl[8];
   logic [15:0] secret_v;

   initial begin
      int n_unl, n_err, n_clr, n_alm, mode, nk;
      secret_v = SECRET;
      tbl[0] = '{keys: 32'h0000_4321, nkeys: 4, exp_cnt: 4, exp_open: 1'b1};
      tbl[1] = '{keys: 32'h0000_5321, nkeys: 4, exp_cnt: 4, exp_open: 1'b0};
      tbl[2] = '{keys: 32'h0432_1B21, nkeys: 7, exp_cnt: 4, exp_open: 1'b1};
      tbl[3] = '{keys: 32'h0009_4321, nkeys: 5, exp_cnt: 4, exp_open: 1'b1};
      tbl[4] = '{keys: 32'h0000_0321, nkeys: 3, exp_cnt: 3, exp_open: 1'b0};
      tbl[5] = '{keys: 32'h0004_3C21, nkeys: 5, exp_cnt: 4, exp_open: 1'b1};
      tbl[6] = '{keys: 32'h0000_1234, nkeys: 4, exp_cnt: 4, exp_open: 1'b0};
      tbl[7] = '{keys: 32'h0000_4321, nkeys: 4, exp_cnt: 4, exp_open: 1'b1};

      repeat (3) @(negedge clk);
      check("rst_unlock", unlock, 1'b0);
      check("rst_alarm", alarm, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_sr_clr", sr_clr, 1'b0);
      check("rst_digit_cnt", digit_cnt, 3'd0);
      clr = 1'b1;
      idle(2);

      for (int t = 0; t < 8; t++) begin
         enter_keys(tbl[t].keys, tbl[t].nkeys, 1);
         check($sformatf("tbl%0d_cnt", t), digit_cnt, tbl[t].exp_cnt);
         if (t == 0) check("tbl0_code_i", code_i, SECRET);
         press(4'hA);
         n_unl = 0; n_err = 0; n_clr = 0;
         for (int c = 0; c < 40; c++) begin
            #2;
            n_unl += int'(unlock);
            n_err += int'(err);
            n_clr += int'(sr_clr);
            @(negedge clk);
         end
         check($sformatf("tbl%0d_unlock_cycles", t), n_unl, tbl[t].exp_open ? OPEN_N : 0);
         check($sformatf("tbl%0d_err_pulses", t), n_err, tbl[t].exp_open ? 0 : 1);
         check($sformatf("tbl%0d_sr_clr_pulses", t), n_clr, 1);
         check($sformatf("tbl%0d_cnt_after", t), digit_cnt, 3'd0);
      end

      // Key C in ENTRY leaves the count alone.
      enter_keys(32'h21, 2, 0);
      press(4'hC);
      check("keyC_cnt", digit_cnt, 3'd2);
      press(4'hB);
      idle(2);

      // ENTER right after the fourth digit.
      enter_keys(32'h4321, 4, 0);
      press(4'hA);
      wait_high("enter_b2b_open", 1'b0, 5);
      idle(12);

      // Three failures in a row, keys during the alarm are dropped.
      for (int f = 0; f < 3; f++) begin
         enter_keys(32'h5555, 4, 0);
         press(4'hA);
         if (f < 2) begin
            idle(3);
            check("no_alarm_yet", alarm, 1'b0);
         end
      end
      wait_high("lockout_rise", 1'b1, 5);
      check("lockout_err", err, 1'b1);
      n_alm = 0;
      for (int c = 0; c < 12; c++) begin
         key_valid = 1'b1;
         key_code  = 4'($urandom_range(0, 11));
         #2;
         n_alm += int'(alarm);
         check("ce_in_alarm", sr_ce, 1'b0);
         @(negedge clk);
      end
      key_valid = 1'b0;
      key_code  = 4'h0;
      for (int c = 0; c < 30; c++) begin
         #2;
         n_alm += int'(alarm);
         @(negedge clk);
      end
      check("alarm_cycles", n_alm, LOCK_N);
      check("cnt_after_alarm", digit_cnt, 3'd0);
      enter_keys(32'h4321, 4, 1);
      press(4'hA);
      wait_high("open_after_alarm", 1'b0, 5);
      idle(12);

      // Reset in the middle of OPEN.
      enter_keys(32'h4321, 4, 0);
      press(4'hA);
      wait_high("open_before_rst", 1'b0, 5);
      idle(3);
      clr = 1'b0;
      #1;
      check("rst_mid_open", unlock, 1'b0);
      @(negedge clk);
      idle(1);
      clr = 1'b1;
      idle(1);
      check("cnt_after_rst", digit_cnt, 3'd0);

      // Reset clears the fail count.
      for (int f = 0; f < 2; f++) begin enter_keys(32'h9999, 4, 0); press(4'hA); idle(3); end
      reset_pulse();
      for (int f = 0; f < 2; f++) begin enter_keys(32'h9999, 4, 0); press(4'hA); idle(3); end
      check("fails_cleared_by_rst", alarm, 1'b0);
      enter_keys(32'h9999, 4, 0);
      press(4'hA);
      wait_high("lockout_before_rst", 1'b1, 5);
      idle(4);
      clr = 1'b0;
      #1;
      check("rst_mid_lockout", alarm, 1'b0);
      @(negedge clk);
      idle(1);
      clr = 1'b1;
      for (int f = 0; f < 2; f++) begin enter_keys(32'h9999, 4, 0); press(4'hA); idle(3); end
      check("fails_cleared_after_lockout_rst", alarm, 1'b0);
      reset_pulse();
      idle(2);

      // Random traffic, checked every cycle by the model.
      for (int it = 0; it < 120; it++) begin
         mode = $urandom_range(0, 19);
         if (mode < 6) begin
            for (int k = 0; k < 4; k++) begin
               press(secret_v[4*k +: 4]);
               idle($urandom_range(0, 1));
            end
            press(4'hA);
         end else if (mode < 11) begin
            for (int k = 0; k < 4; k++) press(4'($urandom_range(0, 9)));
            press(4'hA);
         end else if (mode < 19) begin
            nk = $urandom_range(1, 6);
            for (int k = 0; k < nk; k++) begin
               press(4'($urandom_range(0, 15)));
               idle($urandom_range(0, 2));
            end
         end else begin
            reset_pulse();
         end
         idle($urandom_range(0, 12));
      end
      idle(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
